// File: rtl/tratador_erro_pkg.sv
// tratador_erro_pkg: state encodings, counter limit and fault-code bit positions shared by the fault handler
package tratador_erro_pkg;
  localparam logic [1:0] NORMAL      = 2'd0;
  localparam logic [1:0] CONFIRMANDO = 2'd1;
  localparam logic [1:0] FALHA       = 2'd2;
  localparam logic [1:0] LIBERANDO   = 2'd3;
  localparam logic [7:0] CONT_MAX    = 8'd255;
  localparam int BIT_FRONTAL  = 3;
  localparam int BIT_DIREITO  = 2;
  localparam int BIT_ESQUERDO = 1;
  localparam int BIT_TRAZEIRO = 0;
  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    return (v == CONT_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/tratador_erro_contador_pisca.sv
// contador_pisca: blink timer counting 0..PISCA_CICLOS-1, pulsing Alternar for one cycle on each wrap
module contador_pisca
  import tratador_erro_pkg::*;
#(
  parameter int PISCA_CICLOS = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Habilitar,
  input  logic Reiniciar,
  output logic Alternar
);
  localparam logic [15:0] ULTIMO = 16'(PISCA_CICLOS - 1);
  logic [15:0] timer;
  assign Alternar = Habilitar && !Reiniciar && (timer == ULTIMO);
  always_ff @(posedge Clock) begin
    if (Reset || Reiniciar) timer <= 16'd0;
    else if (Habilitar) timer <= Alternar ? 16'd0 : timer + 16'd1;
  end
endmodule

// File: rtl/tratador_erro.sv
// tratador_erro: filters the sensor fault flag, latches the fault with a sensor snapshot, inhibits the motor and blinks the alarm
module tratador_erro
  import tratador_erro_pkg::*;
#(
  parameter int FILTRO_CICLOS = 4,
  parameter int PISCA_CICLOS  = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Erro,
  input  logic       Sensor_Frontal,
  input  logic       Sensor_Direito,
  input  logic       Sensor_Esquerdo,
  input  logic       Sensor_Trazeiro,
  input  logic       Reconhecer,
  output logic       Motor_Habilitado,
  output logic       Alarme,
  output logic       Falha_Ativa,
  output logic [3:0] Codigo_Erro,
  output logic [7:0] Contador_Falhas
);
  localparam logic [7:0] FILTRO = 8'(FILTRO_CICLOS);
  logic [1:0] estado, prox;
  logic [7:0] filtro, filtro_prox;
  logic       entrada, alternar;
  logic [3:0] sensores;
  always_comb begin
    sensores = 4'd0;
    sensores[BIT_FRONTAL]  = Sensor_Frontal;
    sensores[BIT_DIREITO]  = Sensor_Direito;
    sensores[BIT_ESQUERDO] = Sensor_Esquerdo;
    sensores[BIT_TRAZEIRO] = Sensor_Trazeiro;
  end
  always_comb begin
    prox = estado;
    filtro_prox = 8'd0;
    case (estado)
      NORMAL: if (Erro) begin
        filtro_prox = 8'd1;
        prox = (FILTRO == 8'd1) ? FALHA : CONFIRMANDO;
      end
      CONFIRMANDO: if (Erro) begin
        filtro_prox = filtro + 8'd1;
        prox = (filtro + 8'd1 == FILTRO) ? FALHA : CONFIRMANDO;
      end else prox = NORMAL;
      FALHA:     prox = (Reconhecer && !Erro) ? LIBERANDO : FALHA;
      LIBERANDO: prox = Erro ? FALHA : (Reconhecer ? LIBERANDO : NORMAL);
      default:   prox = FALHA;
    endcase
  end
  assign entrada          = (prox == FALHA) && (estado != FALHA);
  assign Motor_Habilitado = (estado == NORMAL) || (estado == CONFIRMANDO);
  assign Falha_Ativa      = (estado == FALHA) || (estado == LIBERANDO);
  // timer is held at zero outside FALHA, so every entry starts a fresh half-period
  contador_pisca #(.PISCA_CICLOS(PISCA_CICLOS)) u_pisca (
    .Clock    (Clock),
    .Reset    (Reset),
    .Habilitar(estado == FALHA),
    .Reiniciar(estado != FALHA),
    .Alternar (alternar)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado          <= NORMAL;
      filtro          <= 8'd0;
      Alarme          <= 1'b0;
      Codigo_Erro     <= 4'd0;
      Contador_Falhas <= 8'd0;
    end else begin
      estado <= prox;
      filtro <= filtro_prox;
      if (entrada) begin
        Codigo_Erro     <= sensores;
        Contador_Falhas <= inc_sat(Contador_Falhas);
        Alarme          <= 1'b1;
      end else Alarme <= (prox != FALHA) ? 1'b0 : (alternar ? ~Alarme : Alarme);
    end
  end
endmodule
